// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared size, op-type and FSM state encodings for the data-cache arbiter.
package dmem_arbiter_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;
endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: combinational sub-word load extract/extend and store merge into a cache word.
module dmem_lane_unit
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);
  logic [4:0]  w_sh;
  logic [31:0] w_rsh;
  logic [31:0] w_mask;
  assign w_sh   = {i_lane, 3'b000};
  assign w_rsh  = i_rword >> w_sh;
  assign w_mask = (i_size == SZ_B ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
  assign o_load = i_size == SZ_B ? {{24{w_rsh[7] & ~i_unsigned}}, w_rsh[7:0]} :
                  i_size == SZ_H ? {{16{w_rsh[15] & ~i_unsigned}}, w_rsh[15:0]} : i_rword;
  assign o_merged = i_size == SZ_W ? i_wdata : (i_rword & ~w_mask) | ((i_wdata << w_sh) & w_mask);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a single-port data cache between two requesters,
// with sub-word loads/stores; defining DMEM_ARBITER_STATS_EN adds saturating counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] DATA_BASE = 32'h0000_0000,
  parameter int unsigned DATA_SIZE = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_p0_valid,
  output logic        o_p0_ready,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  logic        i_p0_we,
  input  logic [1:0]  i_p0_size,
  input  logic        i_p0_unsigned,
  input  logic        i_p1_valid,
  output logic        o_p1_ready,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  logic        i_p1_we,
  input  logic [1:0]  i_p1_size,
  input  logic        i_p1_unsigned,
  output logic        o_rsp_valid,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_cache_address,
  output logic [31:0] o_cache_val,
  output logic        o_cache_op_type,
  input  logic [31:0] i_cache_val
`ifdef DMEM_ARBITER_STATS_EN
  ,
  output logic [15:0] o_load_cnt,
  output logic [15:0] o_store_cnt,
  output logic [15:0] o_err_cnt
`endif
);
  state_t      r_state;
  logic        r_rr, r_id, r_we, r_uns;
  logic [1:0]  r_lane, r_size;
  logic [31:0] r_wdata;
  logic        w_take, w_grant, w_err;
  logic [31:0] w_addr, w_load, w_merged;
  logic [1:0]  w_size;
  logic [32:0] w_off;
  logic [33:0] w_end;
  assign w_grant    = (i_p0_valid && i_p1_valid) ? r_rr : i_p1_valid;
  assign w_take     = r_state == S_IDLE && (i_p0_valid || i_p1_valid);
  assign o_p0_ready = w_take && !w_grant;
  assign o_p1_ready = w_take && w_grant;
  assign w_addr     = w_grant ? i_p1_addr : i_p0_addr;
  assign w_size     = w_grant ? i_p1_size : i_p0_size;
  // Range check in wider arithmetic: bit 32 of the offset flags addr < DATA_BASE.
  assign w_off = {1'b0, w_addr} - {1'b0, DATA_BASE};
  assign w_end = {1'b0, w_off} + 34'(4'd1 << w_size);
  assign w_err = w_size == 2'd3 || (w_size == SZ_H && w_addr[0]) ||
                 (w_size == SZ_W && w_addr[1:0] != 2'b00) || w_off[32] || w_end > 34'(DATA_SIZE);
  dmem_lane_unit u_lane (
    .i_lane    (r_lane),
    .i_size    (r_size),
    .i_unsigned(r_uns),
    .i_rword   (i_cache_val),
    .i_wdata   (r_wdata),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      r_state         <= S_IDLE;
      r_rr            <= 1'b0;
      r_id            <= 1'b0;
      r_we            <= 1'b0;
      r_uns           <= 1'b0;
      r_lane          <= 2'b00;
      r_size          <= 2'b00;
      r_wdata         <= '0;
      o_rsp_valid     <= 1'b0;
      o_rsp_err       <= 1'b0;
      o_rsp_rdata     <= '0;
      o_cache_address <= '0;
      o_cache_val     <= '0;
      o_cache_op_type <= OP_RD;
    end else begin
      case (r_state)
        S_IDLE: if (w_take) begin
          r_id    <= w_grant;
          r_rr    <= !w_grant;
          r_lane  <= w_addr[1:0];
          r_size  <= w_size;
          r_we    <= w_grant ? i_p1_we : i_p0_we;
          r_uns   <= w_grant ? i_p1_unsigned : i_p0_unsigned;
          r_wdata <= w_grant ? i_p1_wdata : i_p0_wdata;
          if (w_err) begin
            r_state     <= S_RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
          end else begin
            r_state         <= S_RD;
            o_cache_address <= {w_addr[31:2], 2'b00};
          end
        end
        S_RD: if (r_we) begin
          r_state         <= S_WR;
          o_cache_val     <= w_merged;
          o_cache_op_type <= OP_WR;
        end else begin
          r_state     <= S_RESP;
          o_rsp_valid <= 1'b1;
          o_rsp_rdata <= w_load;
        end
        S_WR: begin
          r_state         <= S_RESP;
          o_cache_op_type <= OP_RD;
          o_rsp_valid     <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          o_rsp_valid <= 1'b0;
          o_rsp_err   <= 1'b0;
          o_rsp_rdata <= '0;
        end
      endcase
    end
  assign o_rsp_id = r_id;
`ifdef DMEM_ARBITER_STATS_EN
  logic [15:0] r_load_cnt, r_store_cnt, r_err_cnt;
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (r_state == S_RESP) begin
      if (o_rsp_err) r_err_cnt <= r_err_cnt + 16'(r_err_cnt != 16'hFFFF);
      else if (r_we) r_store_cnt <= r_store_cnt + 16'(r_store_cnt != 16'hFFFF);
      else r_load_cnt <= r_load_cnt + 16'(r_load_cnt != 16'hFFFF);
    end
  assign o_load_cnt  = r_load_cnt;
  assign o_store_cnt = r_store_cnt;
  assign o_err_cnt   = r_err_cnt;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench with a word-array cache model.
module tb_dmem_arbiter;
  logic        i_clk = 1'b0, i_rst = 1'b0;
  logic        i_p0_valid = 0, i_p0_we = 0, i_p0_unsigned = 0;
  logic        i_p1_valid = 0, i_p1_we = 0, i_p1_unsigned = 0;
  logic [31:0] i_p0_addr = 0, i_p0_wdata = 0, i_p1_addr = 0, i_p1_wdata = 0;
  logic [1:0]  i_p0_size = 0, i_p1_size = 0;
  logic        o_p0_ready, o_p1_ready, o_rsp_valid, o_rsp_id, o_rsp_err, o_cache_op_type;
  logic [31:0] o_rsp_rdata, o_cache_address, o_cache_val, i_cache_val;
`ifdef DMEM_ARBITER_STATS_EN
  logic [15:0] o_load_cnt, o_store_cnt, o_err_cnt;
`endif
  logic [31:0] mem [0:255];
  int wcnt = 0;
  int n_chk = 0, n_fail = 0;

  dmem_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_p0_valid(i_p0_valid), .o_p0_ready(o_p0_ready), .i_p0_addr(i_p0_addr),
    .i_p0_wdata(i_p0_wdata), .i_p0_we(i_p0_we), .i_p0_size(i_p0_size), .i_p0_unsigned(i_p0_unsigned),
    .i_p1_valid(i_p1_valid), .o_p1_ready(o_p1_ready), .i_p1_addr(i_p1_addr),
    .i_p1_wdata(i_p1_wdata), .i_p1_we(i_p1_we), .i_p1_size(i_p1_size), .i_p1_unsigned(i_p1_unsigned),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_cache_address(o_cache_address), .o_cache_val(o_cache_val),
    .o_cache_op_type(o_cache_op_type), .i_cache_val(i_cache_val)
`ifdef DMEM_ARBITER_STATS_EN
    , .o_load_cnt(o_load_cnt), .o_store_cnt(o_store_cnt), .o_err_cnt(o_err_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;
  assign i_cache_val = mem[o_cache_address[9:2]];
  always @(posedge i_clk)
    if (o_cache_op_type) begin
      mem[o_cache_address[9:2]] <= o_cache_val;
      wcnt <= wcnt + 1;
    end

  task automatic drive(input bit p, input bit v, input logic [31:0] a, input logic [31:0] wd,
                       input bit we, input logic [1:0] sz, input bit un);
    if (p) begin
      i_p1_valid = v; i_p1_addr = a; i_p1_wdata = wd; i_p1_we = we; i_p1_size = sz; i_p1_unsigned = un;
    end else begin
      i_p0_valid = v; i_p0_addr = a; i_p0_wdata = wd; i_p0_we = we; i_p0_size = sz; i_p0_unsigned = un;
    end
  endtask

  // lat = cycles from the accepting cycle to the response cycle, -1 if none arrived
  task automatic xact(input bit p, input logic [31:0] a, input logic [31:0] wd, input bit we,
                      input logic [1:0] sz, input bit un,
                      output logic [31:0] rd, output logic er, output logic id, output int lat);
    int n = 0;
    rd = '0; er = 1'b0; id = 1'b0; lat = -1;
    @(negedge i_clk);
    drive(p, 1'b1, a, wd, we, sz, un);
    #1;
    while (!(p ? o_p1_ready : o_p0_ready) && n < 20) begin
      @(negedge i_clk); #1; n++;
    end
    @(negedge i_clk);
    drive(p, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    #1;
    for (int k = 1; k <= 6; k++) begin
      if (o_rsp_valid) begin
        lat = k; rd = o_rsp_rdata; er = o_rsp_err; id = o_rsp_id;
        break;
      end
      @(negedge i_clk); #1;
    end
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    #1;
    n_chk++;
    if ({o_rsp_valid, o_rsp_err, o_rsp_id, o_cache_op_type, o_p0_ready, o_p1_ready} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b expected 000000",
        {o_rsp_valid, o_rsp_err, o_rsp_id, o_cache_op_type, o_p0_ready, o_p1_ready});
    end
    n_chk++;
    if ({o_rsp_rdata, o_cache_address, o_cache_val} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data got %h expected 0", {o_rsp_rdata, o_cache_address, o_cache_val});
    end
    i_rst = 1'b1;
  endtask

  task automatic test_load_ext();
    logic [31:0] rd; logic er, id; int lat;
    xact(1'b0, 32'h1, 32'h0, 1'b0, 2'd0, 1'b0, rd, er, id, lat);
    n_chk++;
    if ({lat, id, er, rd} !== {32'sd2, 1'b0, 1'b0, 32'hFFFF_FFAA}) begin
      n_fail++; $display("FAIL byte_signed got lat=%0d id=%b err=%b rd=%h expected lat=2 id=0 err=0 rd=ffffffaa", lat, id, er, rd);
    end
    xact(1'b0, 32'h1, 32'h0, 1'b0, 2'd0, 1'b1, rd, er, id, lat);
    n_chk++;
    if ({lat, er, rd} !== {32'sd2, 1'b0, 32'h0000_00AA}) begin
      n_fail++; $display("FAIL byte_unsigned got lat=%0d err=%b rd=%h expected lat=2 err=0 rd=000000aa", lat, er, rd);
    end
    xact(1'b0, 32'h0, 32'h0, 1'b0, 2'd1, 1'b0, rd, er, id, lat);
    n_chk++;
    if (rd !== 32'hFFFF_AABB) begin
      n_fail++; $display("FAIL half_signed got %h expected ffffaabb", rd);
    end
    xact(1'b0, 32'h2, 32'h0, 1'b0, 2'd1, 1'b1, rd, er, id, lat);
    n_chk++;
    if (rd !== 32'h0000_8899) begin
      n_fail++; $display("FAIL half_unsigned got %h expected 00008899", rd);
    end
  endtask

  task automatic test_store_merge();
    logic [31:0] rd; logic er, id; int lat, w0;
    w0 = wcnt;
    xact(1'b0, 32'h2, 32'hFFFF_1234, 1'b1, 2'd1, 1'b0, rd, er, id, lat);
    n_chk++;
    if ({lat, er, rd} !== {32'sd3, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL half_store got lat=%0d err=%b rd=%h expected lat=3 err=0 rd=0", lat, er, rd);
    end
    n_chk++;
    if (wcnt - w0 !== 1 || mem[0] !== 32'h1234_AABB) begin
      n_fail++; $display("FAIL half_store_mem got writes=%0d word=%h expected writes=1 word=1234aabb", wcnt - w0, mem[0]);
    end
    xact(1'b0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0, rd, er, id, lat);
    n_chk++;
    if ({lat, rd} !== {32'sd2, 32'h1234_AABB}) begin
      n_fail++; $display("FAIL word_load got lat=%0d rd=%h expected lat=2 rd=1234aabb", lat, rd);
    end
    xact(1'b0, 32'h1, 32'h0000_0080, 1'b1, 2'd0, 1'b0, rd, er, id, lat);
    xact(1'b0, 32'h1, 32'h0, 1'b0, 2'd0, 1'b0, rd, er, id, lat);
    n_chk++;
    if (mem[0] !== 32'h1234_80BB || rd !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL byte_store got word=%h rd=%h expected word=123480bb rd=ffffff80", mem[0], rd);
    end
    xact(1'b0, 32'h8, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, rd, er, id, lat);
    n_chk++;
    if (lat !== 3 || mem[2] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL word_store got lat=%0d word=%h expected lat=3 word=deadbeef", lat, mem[2]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, id; int lat, w0;
    w0 = wcnt;
    xact(1'b1, 32'h2, 32'h0, 1'b0, 2'd2, 1'b0, rd, er, id, lat);
    n_chk++;
    if ({lat, id, er, rd} !== {32'sd1, 1'b1, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL misaligned_word got lat=%0d id=%b err=%b rd=%h expected lat=1 id=1 err=1 rd=0", lat, id, er, rd);
    end
    xact(1'b1, 32'h400, 32'h55, 1'b1, 2'd0, 1'b0, rd, er, id, lat);
    n_chk++;
    if ({lat, id, er, rd} !== {32'sd1, 1'b1, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL out_of_range got lat=%0d id=%b err=%b rd=%h expected lat=1 id=1 err=1 rd=0", lat, id, er, rd);
    end
    xact(1'b1, 32'h3FE, 32'h0, 1'b0, 2'd2, 1'b0, rd, er, id, lat);
    n_chk++;
    if ({lat, er} !== {32'sd1, 1'b1}) begin
      n_fail++; $display("FAIL word_past_end got lat=%0d err=%b expected lat=1 err=1", lat, er);
    end
    xact(1'b0, 32'h0, 32'h77, 1'b1, 2'd3, 1'b0, rd, er, id, lat);
    n_chk++;
    if ({lat, id, er} !== {32'sd1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL size3 got lat=%0d id=%b err=%b expected lat=1 id=0 err=1", lat, id, er);
    end
    xact(1'b0, 32'h5, 32'h77, 1'b1, 2'd1, 1'b0, rd, er, id, lat);
    n_chk++;
    if ({lat, er} !== {32'sd1, 1'b1}) begin
      n_fail++; $display("FAIL misaligned_half got lat=%0d err=%b expected lat=1 err=1", lat, er);
    end
    n_chk++;
    if (wcnt !== w0) begin
      n_fail++; $display("FAIL err_no_write got %0d writes expected 0", wcnt - w0);
    end
    xact(1'b1, 32'h3FC, 32'h0, 1'b0, 2'd2, 1'b0, rd, er, id, lat);
    n_chk++;
    if ({lat, id, er, rd} !== {32'sd2, 1'b1, 1'b0, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL last_word got lat=%0d id=%b err=%b rd=%h expected lat=2 id=1 err=0 rd=cafef00d", lat, id, er, rd);
    end
  endtask

  task automatic test_round_robin();
    logic [5:0] ord = '0;
    int got = 0, both = 0, badgap = 0, last = 0;
    apply_reset();
    @(negedge i_clk);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0);
    drive(1'b1, 1'b1, 32'h3FC, 32'h0, 1'b0, 2'd2, 1'b0);
    #1;
    for (int c = 0; c < 60 && got < 6; c++) begin
      if (o_p0_ready && o_p1_ready) both++;
      if (o_p0_ready || o_p1_ready) begin
        ord[got] = o_p1_ready;
        if (got > 0 && c - last != 3) badgap++;
        last = c;
        got++;
      end
      @(negedge i_clk); #1;
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    repeat (3) @(negedge i_clk);
    n_chk++;
    if (got !== 6 || ord !== 6'b101010) begin
      n_fail++; $display("FAIL rr_order got n=%0d order=%b expected n=6 order=101010", got, ord);
    end
    n_chk++;
    if (both !== 0 || badgap !== 0) begin
      n_fail++; $display("FAIL rr_ready got both=%0d badgap=%0d expected 0 0", both, badgap);
    end
  endtask

  task automatic test_reset_in_wr();
    logic [31:0] rd; logic er, id; int lat, n = 0, w0, seen = 0;
    @(negedge i_clk);
    drive(1'b0, 1'b1, 32'h4, 32'hEE, 1'b1, 2'd0, 1'b0);
    #1;
    while (!o_p0_ready && n < 20) begin @(negedge i_clk); #1; n++; end
    @(negedge i_clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    #1; n = 0;
    while (!o_cache_op_type && n < 5) begin @(negedge i_clk); #1; n++; end
    n_chk++;
    if (o_cache_op_type !== 1'b1) begin
      n_fail++; $display("FAIL wr_reached got op=%b expected 1", o_cache_op_type);
    end
    w0 = wcnt;
    i_rst = 1'b0;
    #1;
    n_chk++;
    if (o_cache_op_type !== 1'b0 || o_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got op=%b rsp=%b expected 0 0", o_cache_op_type, o_rsp_valid);
    end
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1; if (o_rsp_valid) seen++;
      @(negedge i_clk);
    end
    n_chk++;
    if (seen !== 0 || wcnt !== w0 || mem[1] !== 32'h0) begin
      n_fail++; $display("FAIL abandoned got rsp=%0d writes=%0d word=%h expected 0 0 00000000", seen, wcnt - w0, mem[1]);
    end
    xact(1'b0, 32'h4, 32'h0, 1'b0, 2'd2, 1'b0, rd, er, id, lat);
    n_chk++;
    if ({lat, er, rd} !== {32'sd2, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL idle_after_reset got lat=%0d err=%b rd=%h expected lat=2 err=0 rd=0", lat, er, rd);
    end
  endtask

`ifdef DMEM_ARBITER_STATS_EN
  task automatic test_stats();
    logic [31:0] rd; logic er, id; int lat;
    apply_reset();
    xact(1'b0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0, rd, er, id, lat);
    xact(1'b1, 32'h1, 32'h0, 1'b0, 2'd0, 1'b0, rd, er, id, lat);
    xact(1'b0, 32'hC, 32'h55, 1'b1, 2'd2, 1'b0, rd, er, id, lat);
    xact(1'b1, 32'h401, 32'h0, 1'b0, 2'd0, 1'b0, rd, er, id, lat);
    @(negedge i_clk);
    n_chk++;
    if ({o_load_cnt, o_store_cnt, o_err_cnt} !== {16'd2, 16'd1, 16'd1}) begin
      n_fail++; $display("FAIL stats got %0d/%0d/%0d expected 2/1/1", o_load_cnt, o_store_cnt, o_err_cnt);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h8899_AABB;
    mem[255] = 32'hCAFE_F00D;
    test_reset();
    test_load_ext();
    test_store_merge();
    test_errors();
    test_round_robin();
    test_reset_in_wr();
`ifdef DMEM_ARBITER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
